// File: rtl/sdram_burst_interface.sv
// Burst front end for the SDRAM controller: packs a streamed write burst into one
// controller block, issues a single request, and unpacks read blocks onto a stream.
module sdram_burst_interface #(
  parameter int UI_BW_ADDR      = 25,
  parameter int UI_BW_DATA      = 32,
  parameter int BW_BURST_LENGTH = 4,
  parameter int BW_ADDR         = 25,
  parameter int BW_DATA_BLOCK   = 512
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic                       req_i,
  input  logic                       rw_i,
  input  logic [BW_BURST_LENGTH-1:0] len_i,
  input  logic [UI_BW_ADDR-1:0]      addr_i,
  output logic                       ready_o,
  input  logic                       wr_valid_i,
  input  logic [UI_BW_DATA-1:0]      wr_data_i,
  output logic                       wr_ready_o,
  output logic                       rd_valid_o,
  output logic [UI_BW_DATA-1:0]      rd_data_o,
  input  logic                       rd_ready_i,
  output logic                       done_o,
  input  logic                       clear_i,
  output logic                       sdram_request_o,
  output logic                       sdram_command_o,
  output logic [BW_BURST_LENGTH-1:0] sdram_length_o,
  output logic [BW_ADDR-1:0]         sdram_address_o,
  output logic [BW_DATA_BLOCK-1:0]   sdram_data_o,
  input  logic                       sdram_ready_i,
  input  logic                       sdram_done_i,
  input  logic [BW_DATA_BLOCK-1:0]   sdram_data_i,
  output logic [2:0]                 state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFILL  = 3'd1,
    S_ISSUE  = 3'd2,
    S_GUARD  = 3'd3,
    S_WAIT   = 3'd4,
    S_RDRAIN = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [BW_BURST_LENGTH-1:0] cnt_q;
  logic [BW_DATA_BLOCK-1:0]   rd_block_q;

  // Stream handshakes: a word moves on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the registered-state strobes never depend on inputs.
  logic wr_fire, rd_fire, last_word;
  assign wr_fire   = (state_q == S_WFILL) && wr_valid_i;
  assign rd_fire   = (state_q == S_RDRAIN) && rd_ready_i;
  assign last_word = (cnt_q == sdram_length_o);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_i) state_d = rw_i ? S_WFILL : S_ISSUE;
      S_WFILL:  if (wr_fire && last_word) state_d = S_ISSUE;
      S_ISSUE:  if (sdram_ready_i) state_d = S_GUARD;
      // GUARD masks a done/ready left over from the controller's previous cycle.
      S_GUARD:  state_d = S_WAIT;
      S_WAIT:   if (sdram_done_i) state_d = sdram_command_o ? S_DONE : S_RDRAIN;
      S_RDRAIN: if (rd_fire && last_word) state_d = S_DONE;
      S_DONE:   if (clear_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Write block doubles as sdram_data_o; read data lands in a separate block so the
  // controller-facing buses stay stable for the whole command.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sdram_command_o <= 1'b0;
      sdram_length_o  <= '0;
      sdram_address_o <= '0;
      sdram_data_o    <= '0;
      rd_block_q      <= '0;
      cnt_q           <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            sdram_command_o <= rw_i;
            sdram_length_o  <= len_i;
            sdram_address_o <= BW_ADDR'(addr_i);
            sdram_data_o    <= '0;
            rd_block_q      <= '0;
            cnt_q           <= '0;
          end
        end
        S_WFILL: begin
          if (wr_fire) begin
            sdram_data_o[cnt_q*UI_BW_DATA +: UI_BW_DATA] <= wr_data_i;
            if (!last_word) cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (sdram_done_i && !sdram_command_o) begin
            rd_block_q <= sdram_data_i;
            cnt_q      <= '0;
          end
        end
        S_RDRAIN: begin
          if (rd_fire && !last_word) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_o         = (state_q == S_IDLE);
  assign wr_ready_o      = (state_q == S_WFILL);
  assign rd_valid_o      = (state_q == S_RDRAIN);
  assign done_o          = (state_q == S_DONE);
  assign sdram_request_o = (state_q == S_ISSUE) && sdram_ready_i;
  assign rd_data_o       = rd_block_q[cnt_q*UI_BW_DATA +: UI_BW_DATA];
  assign state_o         = state_q;

endmodule

// File: tb/tb_sdram_burst_interface.sv
// Directed bench for sdram_burst_interface: a command table driven cycle by cycle
// against a behavioural controller, plus reset and handshake corner sequences.
module tb_sdram_burst_interface;
  localparam int W  = 32;
  localparam int BL = 4;
  localparam int N  = 16;
  localparam int AW = 25;
  localparam int BW = 512;

  logic          clock_i = 1'b0;
  logic          resetn_i;
  logic          req_i, rw_i;
  logic [BL-1:0] len_i;
  logic [AW-1:0] addr_i;
  logic          ready_o;
  logic          wr_valid_i;
  logic [W-1:0]  wr_data_i;
  logic          wr_ready_o, rd_valid_o;
  logic [W-1:0]  rd_data_o;
  logic          rd_ready_i, done_o, clear_i;
  logic          sdram_request_o, sdram_command_o;
  logic [BL-1:0] sdram_length_o;
  logic [AW-1:0] sdram_address_o;
  logic [BW-1:0] sdram_data_o;
  logic          sdram_ready_i, sdram_done_i;
  logic [BW-1:0] sdram_data_i;
  logic [2:0]    state_o;

  sdram_burst_interface dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .req_i(req_i), .rw_i(rw_i),
    .len_i(len_i), .addr_i(addr_i), .ready_o(ready_o),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .done_o(done_o), .clear_i(clear_i),
    .sdram_request_o(sdram_request_o), .sdram_command_o(sdram_command_o),
    .sdram_length_o(sdram_length_o), .sdram_address_o(sdram_address_o),
    .sdram_data_o(sdram_data_o), .sdram_ready_i(sdram_ready_i),
    .sdram_done_i(sdram_done_i), .sdram_data_i(sdram_data_i), .state_o(state_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [BL-1:0] len;
    logic [AW-1:0] addr;
    logic [W-1:0]  base;        // word i of the burst is base+i
    int            rdy_from;    // cycle from which sdram_ready_i is high
    int            dly;         // cycles from request pulse to sdram_done_i
    bit            wr_toggle;   // wr_valid_i only on odd cycles
    bit            rd_stall;    // rd_ready_i low for 2 cycles after first word
    bit            guard_pulse; // extra sdram_done_i during GUARD
    int            exp_done;    // cycle (accept = 0) at which done_o is first seen
  } vec_t;

  vec_t vecs[6];

  task automatic idle_inputs();
    req_i = 1'b0; rw_i = 1'b0; len_i = '0; addr_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0; clear_i = 1'b0;
    sdram_ready_i = 1'b0; sdram_done_i = 1'b0; sdram_data_i = '0;
  endtask

  // driver: one full command, behaving as the controller and the user side
  task automatic run_cmd(input vec_t v);
    int req_cyc  = -1;
    int req_cnt  = 0;
    int sent     = 0;
    int done_cyc = -1;
    logic [W-1:0]  e;
    logic [BW-1:0] rblk;
    exp_q.delete();
    for (int i = 0; i < N; i++)
      rblk[i*W +: W] = (i <= int'(v.len)) ? v.base + W'(i) : 32'hFFFF_FFFF;
    if (!v.rw)
      for (int i = 0; i <= int'(v.len); i++) exp_q.push_back(v.base + W'(i));

    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      @(negedge clock_i);
      req_i         = (cyc == 0);
      rw_i          = v.rw;
      len_i         = v.len;
      addr_i        = v.addr;
      clear_i       = (cyc == 1 || cyc == 2);
      wr_valid_i    = v.wr_toggle ? (cyc % 2 == 1) : 1'b1;
      wr_data_i     = v.base + W'(sent);
      sdram_ready_i = (cyc >= v.rdy_from);
      sdram_done_i  = (cyc == 1) ||
                      (req_cyc >= 0 && (cyc == req_cyc + v.dly ||
                                        (v.guard_pulse && cyc == req_cyc + 1)));
      sdram_data_i  = rblk;
      rd_ready_i    = !(v.rd_stall && req_cyc >= 0 &&
                        (cyc == req_cyc + v.dly + 2 || cyc == req_cyc + v.dly + 3));
      #1;
      if (cyc == 0) begin
        chk("ready_at_accept", ready_o, 1);
        chk("idle_at_accept", state_o, 0);
      end
      if (done_o) begin
        done_cyc = cyc;
      end else begin
        if (sdram_request_o) begin
          req_cnt++;
          if (req_cyc < 0) req_cyc = cyc;
          chk("req_command", sdram_command_o, v.rw);
          chk("req_length", sdram_length_o, v.len);
          chk("req_address", sdram_address_o, v.addr);
          if (!v.rw) chk("req_rd_block_clear", (sdram_data_o == '0), 1);
        end
        if (v.guard_pulse && req_cyc >= 0 && cyc == req_cyc + 2)
          chk("wait_after_guard_done", state_o, 4);
        if (wr_valid_i && wr_ready_o) sent++;
        if (rd_valid_o && rd_ready_i) begin
          if (exp_q.size() == 0) chk("rd_extra_word", rd_data_o, 0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data_o, e);
          end
        end
      end
    end

    chk("done_seen", (done_cyc >= 0), 1);
    chk("done_cycle", done_cyc, v.exp_done);
    chk("request_pulses", req_cnt, 1);
    chk("wr_words", sent, v.rw ? int'(v.len) + 1 : 0);
    chk("rd_words_left", exp_q.size(), 0);
    chk("hold_command", sdram_command_o, v.rw);
    chk("hold_address", sdram_address_o, v.addr);
    for (int i = 0; i < N; i++)
      chk("blk_word", sdram_data_o[i*W +: W],
          (v.rw && i <= int'(v.len)) ? v.base + W'(i) : '0);

    // done held until clear; req_i in DONE ignored; req with clear not accepted
    for (int k = 0; k < 2; k++) begin
      @(negedge clock_i);
      req_i = 1'b1; clear_i = 1'b0; sdram_done_i = 1'b0;
      #1;
      chk("done_held", done_o, 1);
      chk("ready_low_in_done", ready_o, 0);
    end
    @(negedge clock_i);
    clear_i = 1'b1; req_i = 1'b1;
  endtask

  initial begin
    // command table: exp_done hand-derived from request/done timing
    //           rw    len    addr          base           rdy dly tog stl grd exp
    vecs[0] = '{1'b1, 4'd0,  25'h0000010,  32'hDEADBEEF,  0,  3,  0,  0,  0,  6};
    vecs[1] = '{1'b1, 4'd15, 25'h0123456,  32'h00000000,  0,  3,  1,  0,  0,  36};
    vecs[2] = '{1'b0, 4'd3,  25'h0000200,  32'h000000A0,  0,  5,  0,  1,  0,  13};
    vecs[3] = '{1'b0, 4'd0,  25'h1FFFFFF,  32'h00005555,  11, 3,  0,  0,  0,  16};
    vecs[4] = '{1'b1, 4'd7,  25'h0000003,  32'h00001000,  0,  4,  0,  0,  1,  14};
    vecs[5] = '{1'b0, 4'd15, 25'h0000077,  32'hC0DE0000,  0,  2,  0,  0,  0,  20};

    idle_inputs();
    resetn_i = 1'b0;
    sdram_ready_i = 1'b1;
    repeat (2) @(negedge clock_i);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_request", sdram_request_o, 0);
    chk("rst_data_zero", (sdram_data_o == '0), 1);
    chk("rst_state", state_o, 0);
    @(negedge clock_i);
    resetn_i = 1'b1;

    // asynchronous reset in the middle of a write fill
    @(negedge clock_i);
    req_i = 1'b1; rw_i = 1'b1; len_i = 4'd5; addr_i = 25'h155;
    @(negedge clock_i);
    req_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 32'h11;
    #1 chk("mid_wfill_entered", wr_ready_o, 1);
    @(negedge clock_i);
    wr_data_i = 32'h22;
    #2 resetn_i = 1'b0;
    #1;
    chk("async_rst_ready", ready_o, 1);
    chk("async_rst_wr_ready", wr_ready_o, 0);
    chk("async_rst_done", done_o, 0);
    chk("async_rst_request", sdram_request_o, 0);
    chk("async_rst_command", sdram_command_o, 0);
    chk("async_rst_length", sdram_length_o, 0);
    chk("async_rst_address", sdram_address_o, 0);
    chk("async_rst_data_zero", (sdram_data_o == '0), 1);
    @(negedge clock_i);
    idle_inputs();
    resetn_i = 1'b1;

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    @(negedge clock_i);
    req_i = 1'b0; clear_i = 1'b0;
    #1;
    chk("idle_after_clear", ready_o, 1);
    chk("state_after_clear", state_o, 0);

    // stale controller done while idle
    @(negedge clock_i);
    sdram_done_i = 1'b1;
    @(negedge clock_i);
    sdram_done_i = 1'b0;
    #1;
    chk("stale_done_ready", ready_o, 1);
    chk("stale_done_state", state_o, 0);
    chk("stale_done_done", done_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_burst_interface.md
# sdram_burst_interface

Parametrised user-side front end for the SDRAM controller, replacing the single-word protocol interface. It accepts one read or write command covering 1 to 2^BW_BURST_LENGTH consecutive words. For writes, it packs user words streamed over a valid/ready port into one controller data block; for reads, it unpacks the returned block onto a valid/ready output stream. It sits between the user logic or cache and the SDRAM controller's request/ready/done port, and keeps the done/clear completion handshake.

## Interface
- UI_BW_ADDR, 25: user address width.
- UI_BW_DATA, 32: user word width (W).
- BW_BURST_LENGTH, 4: length field width. Max words per command N = 2^BW_BURST_LENGTH.
- BW_ADDR, 25: controller address width. Must be ≥ UI_BW_ADDR; the address is zero-extended.
- BW_DATA_BLOCK, 512: controller block width. Must equal UI_BW_DATA*N.
- clock_i  in  1  single clock, rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  command request; sampled only in IDLE.
- rw_i  in  1  0 read, 1 write.
- len_i  in  BW_BURST_LENGTH  number of words minus 1.
- addr_i  in  UI_BW_ADDR  start address.
- ready_o  out  1  high only in IDLE.
- wr_valid_i / wr_data_i  in  1 / W  write word stream.
- wr_ready_o  out  1  high in WFILL.
- rd_valid_o / rd_data_o  out  1 / W  read word stream.
- rd_ready_i  in  1  read stream accept.
- done_o  out  1  command complete; held until clear_i.
- clear_i  in  1  acknowledges done_o.
- sdram_request_o  out  1  one-cycle request pulse.
- sdram_command_o  out  1  latched rw_i.
- sdram_length_o  out  BW_BURST_LENGTH  latched len_i.
- sdram_address_o  out  BW_ADDR  latched addr_i.
- sdram_data_o  out  BW_DATA_BLOCK  packed write block.
- sdram_ready_i  in  1  controller can accept a request.
- sdram_done_i  in  1  controller finished; for reads, sdram_data_i is valid in this cycle.
- sdram_data_i  in  BW_DATA_BLOCK  read block.

## Operation
- States: IDLE, WFILL, ISSUE, GUARD, WAIT, RDRAIN, DONE. Word counter cnt has BW_BURST_LENGTH bits.
- IDLE, on req_i:
  - Latch rw, len, addr.
  - Clear the block register to 0 and set cnt=0.
  - Go to WFILL if rw_i=1, otherwise go to ISSUE.
- WFILL: on wr_valid_i & wr_ready_o:
  - Write the word to block[cnt*W +: W].
  - If cnt==len, go to ISSUE; otherwise cnt+1.
  - Words above len stay 0.
- ISSUE: when sdram_ready_i=1, pulse sdram_request_o for exactly one cycle and go to GUARD. Otherwise wait with no request.
- GUARD: one cycle, unconditionally goes to WAIT. sdram_done_i is ignored here, covering the controller's late deassertion of ready/done.
- WAIT, on sdram_done_i:
  - Write command: go to DONE.
  - Read command: capture sdram_data_i into the block register, set cnt=0, go to RDRAIN.
- RDRAIN:
  - rd_valid_o=1 and rd_data_o=block[cnt*W +: W].
  - On rd_ready_i: if cnt==len, go to DONE; otherwise cnt+1.
- DONE: done_o=1. On clear_i, go to IDLE.
- ready_o, wr_ready_o, rd_valid_o and done_o are decoded from the registered state only. No input reaches them combinationally.
- sdram_command_o, sdram_length_o, sdram_address_o and sdram_data_o are registered and stay stable from command acceptance until the next acceptance.
- Reset values:
  - ready_o=1.
  - All other outputs 0, including sdram_* buses, rd_data_o, the block register and cnt.
  - State = IDLE.

## Timing
- Write, len=L, with wr_valid_i and sdram_ready_i held high; req accepted at cycle 0:
  - Words are accepted at cycles 1..L+1.
  - Request pulse at L+2.
  - GUARD at L+3.
  - If sdram_done_i arrives at cycle k ≥ L+4, done_o rises at k+1.
- Read, with sdram_ready_i high; req accepted at cycle 0:
  - Request pulse at cycle 1, GUARD at cycle 2, WAIT from cycle 3.
  - If sdram_done_i arrives at cycle k, the first rd_valid_o is at k+1.
  - With rd_ready_i high, one word per cycle. done_o rises the cycle after the last handshake.
- Back-pressure: a deasserted wr_valid_i or rd_ready_i stalls with no loss or duplication of words.
- req_i outside IDLE is ignored. clear_i outside DONE is ignored. sdram_done_i outside WAIT is ignored.
- clear_i in DONE: IDLE next cycle and ready_o=1 next cycle. A req_i coinciding with clear_i is not accepted.
- len=N-1: the block is fully used. cnt reaches all-ones and does not wrap before the exit transition.
- Reset asserted mid-operation: immediate return to IDLE with reset values. Any in-flight controller operation is abandoned and not reissued. Stale sdram_done_i after reset is ignored because the block is in IDLE.

## Test plan
- Reset check: assert reset with resetn_i=0 mid-WFILL -> ready_o=1, wr_ready_o=0, done_o=0, sdram_request_o=0 asynchronously; after release, a write command works normally.
- Single write: len=0, addr=0x10, word 0xDEADBEEF -> one request pulse with command=1, length=0, address=0x10, sdram_data_o[31:0]=0xDEADBEEF, upper bits 0; done_o held until clear_i.
- Full write: len=15, words 0..15 with wr_valid_i toggling every other cycle -> exactly 16 accepted words; sdram_data_o[32i+:32]=i; a single request pulse.
- Read burst: len=3, controller returns block word i = 0xA0+i, done_i asserted 5 cycles after the request, rd_ready_i deasserted for 2 cycles mid-stream -> rd_data_o sequence 0xA0, 0xA1, 0xA2, 0xA3 with no repeats; done_o rises after the 4th handshake.
- sdram_ready_i low for 10 cycles in ISSUE -> no request until it rises; sdram_done_i asserted during the GUARD cycle is ignored and the block stays in WAIT.
- req_i held high during DONE together with clear_i -> the block returns to IDLE; the new command is accepted one cycle later; no double acceptance.
